// File: rtl/mem_access_unit.sv
// ----------------------------------------------------------------------------
// mem_access_unit
//
// Memory-stage data-memory initiator for the LC-3b pipeline. It accepts one
// load/store per instruction from the EX/MEM register, runs a word, byte or
// indirect access on the data-memory port, and holds the upstream pipeline
// until the access completes. Load data is returned for the MEM/WB register.
//
// Handshakes:
//   - Pipeline side: a memory op is req_valid && (req_read || req_write). It is
//     captured on the clock edge in IDLE. stall stays high until the op
//     reaches DONE, so upstream must hold req_* while stall is high.
//     result_valid pulses for exactly one cycle, in DONE.
//   - Memory side: mem_read/mem_write are held high with address, data and
//     byte enables stable until the cycle in which mem_resp is sampled high.
//     The strobe drops on the following cycle. mem_resp is ignored whenever
//     no strobe is driven.
//
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   req_*             EX/MEM request (valid, read, write, byte, indirect,
//                     effective address, store data)
//   stall             hold upstream pipeline registers
//   result_valid      one-cycle completion pulse
//   result_data       load result (held between loads)
//   mem_*             data-memory port (address, read, write, byte_enable,
//                     wdata, rdata, resp)
// ----------------------------------------------------------------------------
module mem_access_unit #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  input  logic             req_read,
  input  logic             req_write,
  input  logic             req_byte,
  input  logic             req_indirect,
  input  logic [WIDTH-1:0] req_addr,
  input  logic [WIDTH-1:0] req_wdata,
  output logic             stall,
  output logic             result_valid,
  output logic [WIDTH-1:0] result_data,
  output logic [WIDTH-1:0] mem_address,
  output logic             mem_read,
  output logic             mem_write,
  output logic [1:0]       mem_byte_enable,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic [WIDTH-1:0] mem_rdata,
  input  logic             mem_resp
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] INDIRECT = 2'd1;
  localparam logic [1:0] ACCESS   = 2'd2;
  localparam logic [1:0] DONE     = 2'd3;

  logic [1:0]       state;
  logic             cap_read;
  logic             cap_byte;
  logic [WIDTH-1:0] cap_addr;
  logic [WIDTH-1:0] cap_wdata;

  logic             mem_op;
  logic [WIDTH-1:0] word_addr;
  logic [7:0]       rd_byte;

  assign mem_op    = req_valid && (req_read || req_write);
  assign word_addr = {cap_addr[WIDTH-1:1], 1'b0};
  // Odd addresses select the high byte lane.
  assign rd_byte   = cap_addr[0] ? mem_rdata[15:8] : mem_rdata[7:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      cap_read    <= 1'b0;
      cap_byte    <= 1'b0;
      cap_addr    <= '0;
      cap_wdata   <= '0;
      result_data <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (mem_op) begin
            // A request with both read and write set is treated as a load.
            cap_read  <= req_read;
            // Indirect accesses are always word-wide.
            cap_byte  <= req_byte && !req_indirect;
            cap_addr  <= req_addr;
            cap_wdata <= req_wdata;
            state     <= req_indirect ? INDIRECT : ACCESS;
          end
        end
        INDIRECT: begin
          if (mem_resp) begin
            // Pointer fetched: it becomes the effective address.
            cap_addr <= mem_rdata;
            state    <= ACCESS;
          end
        end
        ACCESS: begin
          if (mem_resp) begin
            if (cap_read) begin
              result_data <= cap_byte ? {{(WIDTH-8){1'b0}}, rd_byte} : mem_rdata;
            end
            state <= DONE;
          end
        end
        DONE: begin
          // The request still on req_* is the one just completed.
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    stall           = 1'b0;
    mem_read        = 1'b0;
    mem_write       = 1'b0;
    mem_address     = word_addr;
    mem_byte_enable = 2'b11;
    mem_wdata       = cap_wdata;
    case (state)
      IDLE: begin
        stall = mem_op;
      end
      INDIRECT: begin
        stall    = 1'b1;
        mem_read = 1'b1;
      end
      ACCESS: begin
        stall     = 1'b1;
        mem_read  = cap_read;
        mem_write = !cap_read;
        if (cap_byte) begin
          mem_address     = cap_addr;
          mem_byte_enable = cap_addr[0] ? 2'b10 : 2'b01;
          // Store byte replicated on both lanes; byte enables pick the lane.
          mem_wdata       = {(WIDTH/8){cap_wdata[7:0]}};
        end
      end
      default: begin
      end
    endcase
  end

  assign result_valid = (state == DONE);

endmodule
